// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: widths, beat index and FSM state shared by the adaptor slice
package cacheline_adaptor_pkg;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS = 4;
  typedef logic [1:0] beat_idx_t;
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);
  typedef enum logic [1:0] {idle, read, write, done} adaptor_state_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: cache-side line port and memory-side burst port of the adaptor
// err exists only when CACHELINE_ADAPTOR_ERR_EN is defined
interface cacheline_adaptor_if
  import cacheline_adaptor_pkg::*;
;
  logic [LINE_W-1:0] line_wb;
  logic [LINE_W-1:0] line_fill;
  logic [31:0] address;
  logic read;
  logic write;
  logic resp;
  logic [BEAT_W-1:0] mem_rdata;
  logic [BEAT_W-1:0] mem_wdata;
  logic [31:0] mem_address;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
`ifdef CACHELINE_ADAPTOR_ERR_EN
  logic err;
`endif
  modport master (
    output line_wb, address, read, write, mem_rdata, mem_resp,
    input line_fill, resp, mem_wdata, mem_address, mem_read, mem_write
`ifdef CACHELINE_ADAPTOR_ERR_EN
    , input err
`endif
  );
  modport slave (
    input line_wb, address, read, write, mem_rdata, mem_resp,
    output line_fill, resp, mem_wdata, mem_address, mem_read, mem_write
`ifdef CACHELINE_ADAPTOR_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/cacheline_adaptor_line_buffer.sv
// cacheline_adaptor_line_buffer: line register loaded whole or one beat slot at a time
module cacheline_adaptor_line_buffer
  import cacheline_adaptor_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic load_line,
  input logic [LINE_W-1:0] line_wb,
  input logic load_slot,
  input beat_idx_t idx,
  input logic [BEAT_W-1:0] beat,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] slot
);
  always_ff @(posedge clk) begin
    if (rst) line <= '0;
    else if (load_line) line <= line_wb;
    else if (load_slot) line[idx*BEAT_W +: BEAT_W] <= beat;
  end
  assign slot = line[idx*BEAT_W +: BEAT_W];
endmodule

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: 256-bit cache line <-> four 64-bit memory bursts, lowest slot first
// optional sticky protocol error output enabled by CACHELINE_ADAPTOR_ERR_EN
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.slave bus
);
  adaptor_state_t state, state_n;
  beat_idx_t cnt, cnt_n;
  logic busy, beat, last, accept;
  logic [31:0] addr;
  logic [LINE_W-1:0] fill, held;
  logic [BEAT_W-1:0] slot;
  assign busy = state == read || state == write;
  assign beat = busy && bus.mem_resp;
  assign last = beat && cnt == LAST_BEAT;
  assign accept = state == idle && (bus.read || bus.write);
  always_comb begin
    state_n = state == idle ? (bus.read ? read : bus.write ? write : idle)
            : state == done ? idle : last ? done : state;
    cnt_n = state == idle ? '0 : beat ? cnt + 2'd1 : cnt;
  end
  // fill is captured as the 4th beat arrives so line_fill only changes when a fill completes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= idle;
      cnt <= '0;
      addr <= '0;
      fill <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) addr <= bus.address & ~32'h1f;
      if (last && state == read) fill <= {bus.mem_rdata, held[LINE_W-BEAT_W-1:0]};
    end
  end
  cacheline_adaptor_line_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .load_line(accept && !bus.read),
    .line_wb(bus.line_wb),
    .load_slot(beat && state == read),
    .idx(cnt),
    .beat(bus.mem_rdata),
    .line(held),
    .slot(slot)
  );
  assign bus.line_fill = fill;
  assign bus.mem_wdata = slot;
  assign bus.mem_address = addr;
  assign bus.mem_read = state == read;
  assign bus.mem_write = state == write;
  assign bus.resp = state == done;
`ifdef CACHELINE_ADAPTOR_ERR_EN
  logic err_q, rd_q, wr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= bus.read;
      wr_q <= bus.write;
      if ((bus.mem_resp && !busy) || (state == idle && bus.read && bus.write) ||
          (busy && (bus.read != rd_q || bus.write != wr_q))) err_q <= 1'b1;
    end
  end
  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: vector table plus scoreboard for fills, write-backs and corner sequences
module tb_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  cacheline_adaptor_if bus ();
  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int resp_count = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rd;
    logic [31:0] addr;
    logic [255:0] line;
  } exp_t;
  exp_t resp_q[$];
  logic [63:0] beat_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.resp) begin
        resp_count++;
        if (resp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_o=1 expected no response");
        end else begin
          e = resp_q.pop_front();
          check("sb_address", bus.mem_address, e.addr);
          if (e.rd) check("sb_fill_line", bus.line_fill, e.line);
        end
      end
      if (bus.mem_write && bus.mem_resp) begin
        if (beat_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got beat %h expected none", bus.mem_wdata);
        end else check("sb_wb_beat", bus.mem_wdata, beat_q.pop_front());
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [255:0] line, input logic [15:0] pat,
                     input logic [31:0] exp_addr, output int lat);
    int beats;
    int i;
    exp_t e;
    e.rd = rd;
    e.addr = {addr[31:5], 5'b0};
    e.line = line;
    resp_q.push_back(e);
    if (!rd && wr) for (int k = 0; k < 4; k++) beat_q.push_back(line[k*64 +: 64]);
    bus.read = rd;
    bus.write = wr;
    bus.address = addr;
    bus.line_wb = line;
    @(posedge clk); #1;
    bus.line_wb = '1;
    bus.address = ~addr;
    check("address_o", bus.mem_address, exp_addr);
    beats = 0;
    i = 0;
    lat = 1;
    while (beats < 4 && i < 16) begin
      check("req_o", {bus.mem_read, bus.mem_write}, {rd, !rd && wr});
      bus.mem_resp = pat[i];
      bus.mem_rdata = pat[i] ? line[beats*64 +: 64] : {$urandom, $urandom};
      if (pat[i]) beats++;
      i++;
      @(posedge clk); #1;
      lat++;
    end
    bus.mem_resp = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    check("resp_o", bus.resp, 1);
    check("req_drop", {bus.mem_read, bus.mem_write}, 0);
    @(posedge clk); #1;
    check("resp_pulse_end", bus.resp, 0);
  endtask

  task automatic beats4(input logic [255:0] l);
    for (int k = 0; k < 4; k++) begin
      bus.mem_resp = 1'b1;
      bus.mem_rdata = l[k*64 +: 64];
      @(posedge clk); #1;
    end
    bus.mem_resp = 1'b0;
  endtask

  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] addr;
    logic [255:0] line;
    logic [15:0] pat;
    logic [31:0] exp_addr;
    int exp_lat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v[5];
    logic [255:0] last_fill;
    logic [255:0] l1, l2;
    exp_t e;
    int lat;
    int rc;
    v[0] = '{1'b1, 1'b0, 32'h0000_1234,
             {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'h000f, 32'h0000_1220, 5};
    v[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF,
             {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 16'h0059, 32'hDEAD_BEE0, 8};
    v[2] = '{1'b1, 1'b1, 32'h0000_0040,
             {64'h0123_4567_89ab_cdef, 64'hfeed_face_cafe_f00d, 64'h5555_aaaa_5555_aaaa, 64'h0f0f_f0f0_1234_5678},
             16'h000f, 32'h0000_0040, 5};
    v[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF,
             {64'h8000_0000_0000_0001, 64'h7fff_ffff_ffff_fffe, 64'h0000_0000_ffff_ffff, 64'hffff_ffff_0000_0000},
             16'h0055, 32'hFFFF_FFE0, 8};
    v[4] = '{1'b0, 1'b1, 32'h0000_011f,
             {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0000},
             16'h000f, 32'h0000_0100, 5};

    rst = 1'b1;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.line_wb = '0;
    bus.mem_rdata = '0;
    bus.mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_o", bus.resp, 0);
    check("rst_read_o", bus.mem_read, 0);
    check("rst_write_o", bus.mem_write, 0);
    check("rst_address_o", bus.mem_address, 0);
    check("rst_line_o", bus.line_fill, 0);
    check("rst_burst_o", bus.mem_wdata, 0);
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("rst_err_o", bus.err, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    last_fill = '0;
    for (int i = 0; i < 5; i++) begin
      txn(v[i].rd, v[i].wr, v[i].addr, v[i].line, v[i].pat, v[i].exp_addr, lat);
      check("latency", lat, v[i].exp_lat);
      if (v[i].rd) last_fill = v[i].line;
`ifdef CACHELINE_ADAPTOR_ERR_EN
      if (i == 1) check("err_clean", bus.err, 0);
      if (i == 2) check("err_both_req", bus.err, 1);
`endif
    end
    check("line_held_after_wb", bus.line_fill, last_fill);

    bus.read = 1'b1;
    bus.address = 32'h0000_2000;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      bus.mem_resp = 1'b1;
      bus.mem_rdata = 64'hbad0_bad0_bad0_bad0;
      @(posedge clk); #1;
    end
    bus.mem_resp = 1'b0;
    bus.read = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_read_o", bus.mem_read, 0);
    check("abort_resp_o", bus.resp, 0);
    check("abort_line_o", bus.line_fill, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {bus.mem_read, bus.mem_write, bus.resp}, 0);
    l1 = {64'h4444_0000_4444_0000, 64'h3333_0000_3333_0000, 64'h2222_0000_2222_0000, 64'h1111_0000_1111_0000};
    txn(1'b1, 1'b0, 32'h0000_2008, l1, 16'h000f, 32'h0000_2000, lat);
    check("refill_latency", lat, 5);

    l2 = {64'hcafe_0003_cafe_0003, 64'hcafe_0002_cafe_0002, 64'hcafe_0001_cafe_0001, 64'hcafe_0000_cafe_0000};
    rc = resp_count;
    e.rd = 1'b1;
    e.addr = 32'h0000_3000;
    e.line = l1;
    resp_q.push_back(e);
    e.addr = 32'h0000_4000;
    e.line = l2;
    resp_q.push_back(e);
    bus.read = 1'b1;
    bus.address = 32'h0000_3010;
    @(posedge clk); #1;
    beats4(l1);
    check("held_done_resp", bus.resp, 1);
    bus.address = 32'h0000_4004;
    @(posedge clk); #1;
    check("held_idle_read_o", bus.mem_read, 0);
    check("held_idle_resp_o", bus.resp, 0);
    @(posedge clk); #1;
    check("held_reaccept", bus.mem_read, 1);
    check("held_reaccept_addr", bus.mem_address, 32'h0000_4000);
    beats4(l2);
    bus.read = 1'b0;
    check("held_done2_resp", bus.resp, 1);
    @(posedge clk); #1;
    check("held_resp_count", resp_count - rc, 2);
    last_fill = l2;

`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("err_before_spurious", bus.err, 0);
`endif
    for (int k = 0; k < 3; k++) begin
      bus.mem_resp = 1'b1;
      bus.mem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      check("spurious_line_o", bus.line_fill, last_fill);
      check("spurious_outs", {bus.mem_read, bus.mem_write, bus.resp}, 0);
    end
    bus.mem_resp = 1'b0;
    check("spurious_address_o", bus.mem_address, 32'h0000_4000);
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("err_spurious", bus.err, 1);
`endif
    @(posedge clk); #1;
    check("sb_drained", resp_q.size() + beat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
